// File: rtl/dmem_lsu.sv
// dmem_lsu: word-organised data memory with a built-in load/store unit.
// Byte addresses with byte/half/word sizes are steered onto the four byte
// lanes for stores. Loads are extracted and extended before being registered
// into a one-cycle response that holds its value while the consumer stalls.

module dmem_lsu #(
    parameter int DWIDTH      = 32,
    parameter int DEPTH       = 256,
    parameter int ABITS       = $clog2(DEPTH) + 2,
    parameter bit INIT_ON_RST = 1'b1
) (
    input  logic              m_clk,
    input  logic              m_rst,
    input  logic              m_i_req,
    input  logic              m_i_we,
    input  logic [ABITS-1:0]  m_i_addr,
    input  logic [1:0]        m_i_size,
    input  logic              m_i_unsigned,
    input  logic [DWIDTH-1:0] m_i_store_data,
    input  logic              m_i_stall,
    output logic              m_o_ready,
    output logic              m_o_ack,
    output logic              m_o_err,
    output logic [DWIDTH-1:0] m_o_load_data
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [DWIDTH-1:0] memArray_q [DEPTH];

    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DWIDTH-1:0] loadData_q, loadData_d;

    logic [ABITS-3:0]  wordIdx;
    logic [1:0]        byteOff;
    logic              accept;
    logic              accessErr;
    logic              memWe;
    logic [3:0]        laneMask;
    logic [DWIDTH-1:0] laneData;
    logic [DWIDTH-1:0] rdWord;
    logic [DWIDTH-1:0] rdShifted;
    logic [DWIDTH-1:0] extData;

    assign wordIdx   = m_i_addr[ABITS-1:2];
    assign byteOff   = m_i_addr[1:0];

    // A held response blocks new requests only while the consumer is stalled.
    assign m_o_ready = !(m_o_ack && m_i_stall);
    assign accept    = m_i_req && m_o_ready;

    // Size 11 is never legal; halves need an even offset, words offset zero.
    always_comb begin
        accessErr = 1'b0;
        case (m_i_size)
            SIZE_BYTE: accessErr = 1'b0;
            SIZE_HALF: accessErr = byteOff[0];
            SIZE_WORD: accessErr = (byteOff != 2'b00);
            default:   accessErr = 1'b1;
        endcase
    end

    assign memWe = accept && m_i_we && !accessErr;

    // Replicate the right-aligned store data across lanes and pick the lanes to write.
    always_comb begin
        laneMask = 4'b0000;
        laneData = m_i_store_data;
        case (m_i_size)
            SIZE_BYTE: begin
                laneMask = 4'b0001 << byteOff;
                laneData = {4{m_i_store_data[7:0]}};
            end
            SIZE_HALF: begin
                laneMask = 4'b0011 << byteOff;
                laneData = {2{m_i_store_data[15:0]}};
            end
            SIZE_WORD: begin
                laneMask = 4'b1111;
                laneData = m_i_store_data;
            end
            default: begin
                laneMask = 4'b0000;
                laneData = m_i_store_data;
            end
        endcase
    end

    // Memory array: lane-masked writes, optionally initialised to its index on reset.
    generate
        if (INIT_ON_RST) begin : gInitMem
            always_ff @(posedge m_clk or negedge m_rst) begin
                if (!m_rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        memArray_q[i] <= DWIDTH'(i);
                    end
                end else if (memWe) begin
                    for (int b = 0; b < 4; b++) begin
                        if (laneMask[b]) begin
                            memArray_q[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
                        end
                    end
                end
            end
        end else begin : gPlainMem
            always_ff @(posedge m_clk) begin
                if (memWe) begin
                    for (int b = 0; b < 4; b++) begin
                        if (laneMask[b]) begin
                            memArray_q[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    assign rdWord    = memArray_q[wordIdx];
    assign rdShifted = rdWord >> {byteOff, 3'b000};

    // Extract the addressed byte/half and sign- or zero-extend it to a full word.
    always_comb begin
        extData = rdWord;
        case (m_i_size)
            SIZE_BYTE: extData = m_i_unsigned ? {24'd0, rdShifted[7:0]}
                                              : {{24{rdShifted[7]}}, rdShifted[7:0]};
            SIZE_HALF: extData = m_i_unsigned ? {16'd0, rdShifted[15:0]}
                                              : {{16{rdShifted[15]}}, rdShifted[15:0]};
            default:   extData = rdWord;
        endcase
    end

    // Next response: capture on accept, retire when not stalled, otherwise hold.
    always_comb begin
        ack_d      = ack_q;
        err_d      = err_q;
        loadData_d = loadData_q;
        if (accept) begin
            ack_d      = 1'b1;
            err_d      = accessErr;
            loadData_d = (m_i_we || accessErr) ? '0 : extData;
        end else if (!m_i_stall) begin
            ack_d = 1'b0;
            err_d = 1'b0;
        end
    end

    // Response register; reset discards any in-flight response.
    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            loadData_q <= '0;
        end else begin
            ack_q      <= ack_d;
            err_q      <= err_d;
            loadData_q <= loadData_d;
        end
    end

    assign m_o_ack       = ack_q;
    assign m_o_err       = err_q;
    assign m_o_load_data = loadData_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed checks of the data memory / load-store unit.
// Each scenario task drives its own vectors and compares against
// hand-computed values.

module tb_dmem_lsu;

    localparam int DWIDTH = 32;
    localparam int DEPTH  = 256;
    localparam int ABITS  = 10;

    logic              m_clk;
    logic              m_rst;
    logic              m_i_req;
    logic              m_i_we;
    logic [ABITS-1:0]  m_i_addr;
    logic [1:0]        m_i_size;
    logic              m_i_unsigned;
    logic [DWIDTH-1:0] m_i_store_data;
    logic              m_i_stall;
    logic              m_o_ready;
    logic              m_o_ack;
    logic              m_o_err;
    logic [DWIDTH-1:0] m_o_load_data;

    int errors;
    int checks;

    dmem_lsu #(
        .DWIDTH(DWIDTH),
        .DEPTH(DEPTH),
        .INIT_ON_RST(1'b1)
    ) dut (
        .m_clk(m_clk),
        .m_rst(m_rst),
        .m_i_req(m_i_req),
        .m_i_we(m_i_we),
        .m_i_addr(m_i_addr),
        .m_i_size(m_i_size),
        .m_i_unsigned(m_i_unsigned),
        .m_i_store_data(m_i_store_data),
        .m_i_stall(m_i_stall),
        .m_o_ready(m_o_ready),
        .m_o_ack(m_o_ack),
        .m_o_err(m_o_err),
        .m_o_load_data(m_o_load_data)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        m_clk = 1'b0;
        forever #5 m_clk = ~m_clk;
    end

    // Present one request on the falling edge, let it be taken on the rising
    // edge, then drop the request 1 unit later so outputs can be sampled.
    task automatic issue(input logic we, input logic [ABITS-1:0] addr,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] data);
        @(negedge m_clk);
        m_i_req        = 1'b1;
        m_i_we         = we;
        m_i_addr       = addr;
        m_i_size       = size;
        m_i_unsigned   = uns;
        m_i_store_data = data;
        @(posedge m_clk);
        #1;
        m_i_req = 1'b0;
    endtask

    task automatic checkResp(input string name, input logic expAck,
                             input logic expErr, input logic [31:0] expData);
        checks++;
        if (m_o_ack !== expAck || m_o_err !== expErr || m_o_load_data !== expData) begin
            errors++;
            $display("[TB] FAIL %s: got ack=%b err=%b data=%h, want ack=%b err=%b data=%h",
                     name, m_o_ack, m_o_err, m_o_load_data, expAck, expErr, expData);
        end
    endtask

    task automatic test_reset();
        m_rst = 1'b0;
        #12;
        checks++;
        if (m_o_ack !== 1'b0 || m_o_err !== 1'b0 || m_o_load_data !== 32'h0 || m_o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state: got ack=%b err=%b data=%h ready=%b, want 0 0 0 1",
                     m_o_ack, m_o_err, m_o_load_data, m_o_ready);
        end
        m_i_stall = 1'b1;
        #1;
        checks++;
        if (m_o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_no_ack_ready: got ready=%b, want 1", m_o_ready);
        end
        m_i_stall = 1'b0;
        @(negedge m_clk);
        m_rst = 1'b1;
        issue(1'b0, 10'h010, 2'b10, 1'b0, 32'h0);
        checkResp("reset_init_load", 1'b1, 1'b0, 32'h00000004);
        @(posedge m_clk);
        #1;
        checkResp("ack_retires", 1'b0, 1'b0, 32'h00000004);
    endtask

    task automatic test_store_extend();
        issue(1'b1, 10'h020, 2'b10, 1'b0, 32'h8899AABB);
        checkResp("sw_resp", 1'b1, 1'b0, 32'h0);
        issue(1'b0, 10'h023, 2'b00, 1'b0, 32'h0);
        checkResp("lb_signed", 1'b1, 1'b0, 32'hFFFFFF88);
        issue(1'b0, 10'h021, 2'b00, 1'b1, 32'h0);
        checkResp("lbu", 1'b1, 1'b0, 32'h000000AA);
        issue(1'b0, 10'h022, 2'b01, 1'b0, 32'h0);
        checkResp("lh_signed", 1'b1, 1'b0, 32'hFFFF8899);
        issue(1'b0, 10'h020, 2'b01, 1'b1, 32'h0);
        checkResp("lhu", 1'b1, 1'b0, 32'h0000AABB);
    endtask

    task automatic test_store_byte();
        issue(1'b1, 10'h025, 2'b00, 1'b0, 32'h1234565A);
        checkResp("sb_resp", 1'b1, 1'b0, 32'h0);
        issue(1'b0, 10'h024, 2'b10, 1'b0, 32'h0);
        checkResp("sb_merge", 1'b1, 1'b0, 32'h00005A09);
        issue(1'b1, 10'h02E, 2'b01, 1'b0, 32'hFFFFBEEF);
        issue(1'b0, 10'h02C, 2'b10, 1'b0, 32'h0);
        checkResp("sh_upper_merge", 1'b1, 1'b0, 32'hBEEF000B);
    endtask

    task automatic test_errors();
        issue(1'b0, 10'h021, 2'b01, 1'b0, 32'h0);
        checkResp("lh_misaligned", 1'b1, 1'b1, 32'h0);
        issue(1'b0, 10'h022, 2'b10, 1'b0, 32'h0);
        checkResp("lw_misaligned", 1'b1, 1'b1, 32'h0);
        issue(1'b0, 10'h030, 2'b11, 1'b0, 32'h0);
        checkResp("load_size11", 1'b1, 1'b1, 32'h0);
        issue(1'b1, 10'h029, 2'b10, 1'b0, 32'hDEADBEEF);
        checkResp("sw_misaligned", 1'b1, 1'b1, 32'h0);
        issue(1'b1, 10'h033, 2'b01, 1'b0, 32'hDEADBEEF);
        checkResp("sh_misaligned", 1'b1, 1'b1, 32'h0);
        issue(1'b1, 10'h034, 2'b11, 1'b0, 32'hDEADBEEF);
        checkResp("store_size11", 1'b1, 1'b1, 32'h0);
        issue(1'b0, 10'h028, 2'b10, 1'b0, 32'h0);
        checkResp("err_store_no_write_w", 1'b1, 1'b0, 32'h0000000A);
        issue(1'b0, 10'h030, 2'b10, 1'b0, 32'h0);
        checkResp("err_store_no_write_h", 1'b1, 1'b0, 32'h0000000C);
        issue(1'b0, 10'h034, 2'b10, 1'b0, 32'h0);
        checkResp("err_store_no_write_s", 1'b1, 1'b0, 32'h0000000D);
    endtask

    task automatic test_stall();
        issue(1'b0, 10'h040, 2'b10, 1'b0, 32'h0);
        checkResp("stall_load_issue", 1'b1, 1'b0, 32'h00000010);
        m_i_stall      = 1'b1;
        m_i_req        = 1'b1;
        m_i_we         = 1'b1;
        m_i_addr       = 10'h044;
        m_i_size       = 2'b10;
        m_i_store_data = 32'hDEADBEEF;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (m_o_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_ready cycle %0d: got ready=%b, want 0", c, m_o_ready);
            end
            @(posedge m_clk);
            #1;
            checkResp("stall_hold", 1'b1, 1'b0, 32'h00000010);
        end
        @(negedge m_clk);
        m_i_stall = 1'b0;
        m_i_we    = 1'b0;
        m_i_addr  = 10'h048;
        #1;
        checks++;
        if (m_o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release_ready: got ready=%b, want 1", m_o_ready);
        end
        @(posedge m_clk);
        #1;
        m_i_req = 1'b0;
        checkResp("stall_release_accept", 1'b1, 1'b0, 32'h00000012);
        issue(1'b0, 10'h044, 2'b10, 1'b0, 32'h0);
        checkResp("stalled_store_dropped", 1'b1, 1'b0, 32'h00000011);
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 10'h050, 2'b10, 1'b0, 32'h01020304);
        issue(1'b0, 10'h050, 2'b10, 1'b0, 32'h0);
        checkResp("raw_next_cycle", 1'b1, 1'b0, 32'h01020304);
        issue(1'b0, 10'h3FC, 2'b10, 1'b0, 32'h0);
        checkResp("top_word", 1'b1, 1'b0, 32'h000000FF);
    endtask

    task automatic test_async_reset();
        issue(1'b1, 10'h010, 2'b10, 1'b0, 32'hCAFEF00D);
        issue(1'b0, 10'h010, 2'b10, 1'b0, 32'h0);
        checkResp("pre_reset_load", 1'b1, 1'b0, 32'hCAFEF00D);
        #2;
        m_rst = 1'b0;
        #1;
        checkResp("async_reset_clear", 1'b0, 1'b0, 32'h0);
        @(negedge m_clk);
        m_rst = 1'b1;
        issue(1'b0, 10'h010, 2'b10, 1'b0, 32'h0);
        checkResp("post_reset_reinit", 1'b1, 1'b0, 32'h00000004);
        issue(1'b0, 10'h050, 2'b10, 1'b0, 32'h0);
        checkResp("post_reset_reinit2", 1'b1, 1'b0, 32'h00000014);
    endtask

    // Scenario sequence; every task is self-contained and fixed-length.
    initial begin
        errors         = 0;
        checks         = 0;
        m_rst          = 1'b1;
        m_i_req        = 1'b0;
        m_i_we         = 1'b0;
        m_i_addr       = '0;
        m_i_size       = 2'b10;
        m_i_unsigned   = 1'b0;
        m_i_store_data = '0;
        m_i_stall      = 1'b0;
        #1;
        test_reset();
        test_store_extend();
        test_store_byte();
        test_errors();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
